// File: rtl/interrupt_pkg.sv
// Shared types and constants for the interrupt controller: line count, vector
// defaults, the sequencing FSM states and the priority-pick helper.
package interrupt_pkg;

  localparam int          IRQ_COUNT                  = 9;
  localparam int          ID_W                       = 4;
  localparam logic [15:0] DEFAULT_VECTOR_BASE        = 16'h0010;
  localparam int          DEFAULT_VECTOR_STRIDE_LOG2 = 2;

  typedef enum logic [2:0] {
    IDLE,
    SAVE,
    VECTOR,
    SERVICE,
    RESTORE
  } irq_state_e;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
  } irq_sel_t;

  // Scanning downward lets the lowest-numbered request overwrite higher ones.
  function automatic irq_sel_t pick_lowest(input logic [IRQ_COUNT-1:0] req);
    irq_sel_t sel;
    sel = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (req[i]) begin
        sel.valid = 1'b1;
        sel.id    = ID_W'(i);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/irq_edge_detect.sv
// Two-flop synchronizer per line followed by a registered rising-edge pulse;
// an input first sampled high at edge N yields a one-cycle pulse after edge N+2.
module irq_edge_detect #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] rise_o
);

  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q, rise_q;

  // NOTE: non-blocking assignments make every flop sample the pre-edge value,
  // so this chain really is four stages rather than one collapsed wire.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      rise_q  <= '0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      rise_q  <= sync2_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/interrupt_controller.sv
// Single-level interrupt controller: latches edges, picks the lowest enabled
// line and sequences save / vector / service / restore with registered strobes.
module interrupt_controller
  import interrupt_pkg::*;
#(
  parameter logic [15:0] VECTOR_BASE        = DEFAULT_VECTOR_BASE,
  parameter int          VECTOR_STRIDE_LOG2 = DEFAULT_VECTOR_STRIDE_LOG2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_COUNT-1:0] irq,
  input  logic [IRQ_COUNT-1:0] enable_mask,
  input  logic [15:0]          pc_in,
  input  logic                 instr_boundary,
  input  logic                 reti,
  output logic                 r_backup,
  output logic                 r_restore,
  output logic                 return_address_write,
  output logic [15:0]          return_address_out,
  output logic                 pc_load,
  output logic [15:0]          pc_vector,
  output logic                 in_service,
  output logic [ID_W-1:0]      active_id,
  output logic [IRQ_COUNT-1:0] pending
);

  irq_state_e           state_q, state_d;
  logic [IRQ_COUNT-1:0] irq_rise;
  logic [IRQ_COUNT-1:0] pending_q, pending_d, pending_clr;
  logic [ID_W-1:0]      active_id_q, active_id_d;
  logic [15:0]          ret_addr_q, ret_addr_d;
  logic [15:0]          pc_vector_q, pc_vector_d;
  logic                 save_q, load_q, service_q, restore_q;
  irq_sel_t             sel;

  irq_edge_detect #(
    .WIDTH (IRQ_COUNT)
  ) u_edge (
    .clk     (clk),
    .reset   (reset),
    .async_i (irq),
    .rise_o  (irq_rise)
  );

  assign sel = pick_lowest(pending_q & enable_mask);

  // NOTE: every variable gets its default before the case so that no path
  // leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d     = state_q;
    active_id_d = active_id_q;
    ret_addr_d  = ret_addr_q;
    pending_clr = '0;
    unique case (state_q)
      IDLE: begin
        if (instr_boundary && sel.valid) begin
          active_id_d = sel.id;
          ret_addr_d  = pc_in;
          state_d     = SAVE;
        end
      end
      SAVE: begin
        pending_clr = IRQ_COUNT'(1) << active_id_q;
        state_d     = VECTOR;
      end
      VECTOR:  state_d = SERVICE;
      SERVICE: if (reti) state_d = RESTORE;
      RESTORE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A fresh edge on the line being acknowledged keeps it pending.
    pending_d   = (pending_q & ~pending_clr) | irq_rise;
    pc_vector_d = (state_d == VECTOR)
                  ? VECTOR_BASE + (16'(active_id_q) << VECTOR_STRIDE_LOG2)
                  : pc_vector_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      pending_q   <= '0;
      active_id_q <= '0;
      ret_addr_q  <= '0;
      pc_vector_q <= '0;
      save_q      <= 1'b0;
      load_q      <= 1'b0;
      service_q   <= 1'b0;
      restore_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      active_id_q <= active_id_d;
      ret_addr_q  <= ret_addr_d;
      pc_vector_q <= pc_vector_d;
      save_q      <= (state_d == SAVE);
      load_q      <= (state_d == VECTOR);
      service_q   <= (state_d == SERVICE);
      restore_q   <= (state_d == RESTORE);
    end
  end

  assign r_backup             = save_q;
  assign return_address_write = save_q;
  assign return_address_out   = ret_addr_q;
  assign pc_load              = load_q;
  assign pc_vector            = pc_vector_q;
  assign in_service           = service_q;
  assign r_restore            = restore_q;
  assign active_id            = active_id_q;
  assign pending              = pending_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: inputs change and outputs are
// sampled on the falling clock edge, against hand-computed expectations.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [8:0]  irq;
  logic [8:0]  enable_mask;
  logic [15:0] pc_in;
  logic        instr_boundary;
  logic        reti;
  logic        r_backup, r_restore, return_address_write, pc_load, in_service;
  logic [15:0] return_address_out, pc_vector;
  logic [3:0]  active_id;
  logic [8:0]  pending;

  int n_checks = 0;
  int n_bad    = 0;

  always #5 clk = ~clk;

  interrupt_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .irq                  (irq),
    .enable_mask          (enable_mask),
    .pc_in                (pc_in),
    .instr_boundary       (instr_boundary),
    .reti                 (reti),
    .r_backup             (r_backup),
    .r_restore            (r_restore),
    .return_address_write (return_address_write),
    .return_address_out   (return_address_out),
    .pc_load              (pc_load),
    .pc_vector            (pc_vector),
    .in_service           (in_service),
    .active_id            (active_id),
    .pending              (pending)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".r_backup"},   16'(r_backup),             16'h0);
    check({tag, ".ra_write"},   16'(return_address_write), 16'h0);
    check({tag, ".r_restore"},  16'(r_restore),            16'h0);
    check({tag, ".pc_load"},    16'(pc_load),              16'h0);
    check({tag, ".in_service"}, 16'(in_service),           16'h0);
  endtask

  initial begin
    reset          = 1'b1;
    irq            = '0;
    enable_mask    = 9'h1FF;
    pc_in          = 16'h0000;
    instr_boundary = 1'b0;
    reti           = 1'b0;
    tick(2);

    // Reset state
    check_idle_outputs("rst");
    check("rst.pending",   16'(pending),       16'h0000);
    check("rst.active_id", 16'(active_id),     16'h0000);
    check("rst.ret_addr",  return_address_out, 16'h0000);
    check("rst.pc_vector", pc_vector,          16'h0000);
    reset = 1'b0;
    tick(2);

    // Single line 3: synchronizer latency, save, vector, service
    irq   = 9'h008;
    pc_in = 16'h0123;
    tick(3);
    check("s1.pending_n2", 16'(pending), 16'h0000);
    tick(1);
    check("s1.pending_n3", 16'(pending), 16'h0008);
    instr_boundary = 1'b1;
    tick(1);
    instr_boundary = 1'b0;
    check("s1.save.r_backup", 16'(r_backup),             16'h1);
    check("s1.save.ra_write", 16'(return_address_write), 16'h1);
    check("s1.save.ra_out",   return_address_out,        16'h0123);
    check("s1.save.pc_load",  16'(pc_load),              16'h0);
    tick(1);
    check("s1.vec.pc_load",   16'(pc_load),   16'h1);
    check("s1.vec.pc_vector", pc_vector,      16'h001C);
    check("s1.vec.r_backup",  16'(r_backup),  16'h0);
    check("s1.vec.pending",   16'(pending),   16'h0000);
    tick(1);
    check("s1.svc.in_service", 16'(in_service), 16'h1);
    check("s1.svc.active_id",  16'(active_id),  16'h3);
    check("s1.svc.pc_load",    16'(pc_load),    16'h0);
    tick(3);
    check("s1.svc_hold", 16'(in_service), 16'h1);
    reti = 1'b1;
    tick(1);
    reti = 1'b0;
    check("s1.rst.r_restore",  16'(r_restore),  16'h1);
    check("s1.rst.in_service", 16'(in_service), 16'h0);
    tick(1);
    check("s1.idle.r_restore", 16'(r_restore),  16'h0);
    irq = '0;
    tick(4);

    // Lines 5 and 2 together; boundary held high throughout
    irq            = 9'h024;
    instr_boundary = 1'b1;
    tick(4);
    check("s2.pending", 16'(pending), 16'h0024);
    tick(1);
    check("s2.save2.r_backup",  16'(r_backup),  16'h1);
    check("s2.save2.active_id", 16'(active_id), 16'h2);
    tick(1);
    check("s2.vec2.pc_vector", pc_vector,     16'h0018);
    check("s2.vec2.pc_load",   16'(pc_load),  16'h1);
    check("s2.vec2.pending",   16'(pending),  16'h0020);
    tick(1);
    check("s2.svc2.in_service", 16'(in_service), 16'h1);
    tick(2);
    check("s2.no_nest.in_service", 16'(in_service), 16'h1);
    check("s2.no_nest.r_backup",   16'(r_backup),   16'h0);
    reti = 1'b1;
    tick(1);
    reti = 1'b0;
    check("s2.rst2.r_restore", 16'(r_restore), 16'h1);
    check("s2.rst2.r_backup",  16'(r_backup),  16'h0);
    tick(1);
    check("s2.gap.r_backup",  16'(r_backup),  16'h0);
    check("s2.gap.r_restore", 16'(r_restore), 16'h0);
    tick(1);
    check("s2.save5.r_backup",  16'(r_backup),  16'h1);
    check("s2.save5.active_id", 16'(active_id), 16'h5);
    tick(1);
    check("s2.vec5.pc_vector", pc_vector,    16'h0024);
    check("s2.vec5.pc_load",   16'(pc_load), 16'h1);
    tick(1);
    check("s2.svc5.in_service", 16'(in_service), 16'h1);
    reti = 1'b1;
    tick(1);
    reti           = 1'b0;
    instr_boundary = 1'b0;
    irq            = '0;
    tick(5);
    check_idle_outputs("s2.end");
    check("s2.end.pending", 16'(pending), 16'h0000);

    // Masked line 4, stray reti in IDLE, then unmask
    enable_mask    = 9'h1EF;
    irq            = 9'h010;
    instr_boundary = 1'b1;
    tick(4);
    check("s3.pending_masked", 16'(pending), 16'h0010);
    reti = 1'b1;
    tick(1);
    reti = 1'b0;
    check("s3.idle_reti.r_restore", 16'(r_restore), 16'h0);
    tick(2);
    check("s3.masked.r_backup",   16'(r_backup),   16'h0);
    check("s3.masked.in_service", 16'(in_service), 16'h0);
    enable_mask = 9'h1FF;
    tick(1);
    check("s3.save.r_backup",  16'(r_backup),  16'h1);
    check("s3.save.active_id", 16'(active_id), 16'h4);
    tick(1);
    check("s3.vec.pc_vector", pc_vector, 16'h0020);
    tick(1);
    check("s3.svc.in_service", 16'(in_service), 16'h1);
    reti = 1'b1;
    tick(1);
    reti           = 1'b0;
    instr_boundary = 1'b0;
    irq            = '0;
    check("s3.rst.r_restore", 16'(r_restore), 16'h1);
    tick(1);
    check("s3.idle.r_restore", 16'(r_restore), 16'h0);
    tick(3);

    // New line-3 edge landing in the SAVE cycle that clears pending[3]
    irq = 9'h008;
    tick(4);
    check("s4.pending_first", 16'(pending), 16'h0008);
    irq = '0;
    tick(4);
    irq = 9'h008;
    tick(2);
    instr_boundary = 1'b1;
    tick(1);
    instr_boundary = 1'b0;
    check("s4.save.r_backup",  16'(r_backup),  16'h1);
    check("s4.save.active_id", 16'(active_id), 16'h3);
    tick(1);
    check("s4.set_wins.pending", 16'(pending), 16'h0008);
    check("s4.vec.pc_vector",    pc_vector,    16'h001C);
    tick(1);
    reti = 1'b1;
    tick(1);
    reti = 1'b0;
    tick(1);

    // Re-service line 3, then reset during SERVICE
    instr_boundary = 1'b1;
    tick(1);
    instr_boundary = 1'b0;
    check("s5.save.r_backup", 16'(r_backup), 16'h1);
    tick(1);
    check("s5.vec.pending", 16'(pending), 16'h0000);
    tick(1);
    check("s5.svc.in_service", 16'(in_service), 16'h1);
    #2 reset = 1'b1;
    #1;
    check_idle_outputs("s5.async");
    check("s5.async.pending",   16'(pending),       16'h0000);
    check("s5.async.active_id", 16'(active_id),     16'h0000);
    check("s5.async.ret_addr",  return_address_out, 16'h0000);
    check("s5.async.pc_vector", pc_vector,          16'h0000);
    tick(2);
    reset = 1'b0;
    irq   = '0;
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("s5.after.r_restore",  16'(r_restore),  16'h0);
      check("s5.after.in_service", 16'(in_service), 16'h0);
    end

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
